prog_run_seq: RTL and testbench
===============================

# prog_run_seq

Host-side initiator for the core's `req`/`done` handshake. It sequences the core through each of the P resident programs (for example encode, decode, and the SECDED variant) in order. For each program it drives `prog_sel` and pulses `req`, waits for the level `done` from the core, and records the cycle count. A watchdog aborts a program that never finishes. The block sits between the test bench or host controller and the processor top level, and replaces manual `req` toggling.

## Interface
Parameters:
- P, 3, number of programs run per sequence
- CW, 16, width of the cycle counter and `cyc_count`
- TIMEOUT, 4095, cycles allowed per program before abort; must satisfy TIMEOUT < 2^CW
- REQ_CYC, 2, width of each `req` pulse in cycles, ≥1

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin a full sequence; sampled only in IDLE and ERROR
- req  out  1  request to the core
- prog_sel  out  $clog2(P)  index of the program being run
- done  in  1  level from the core; high when its program has finished
- busy  out  1  high in every state except IDLE, FINISH and ERROR
- cyc_valid  out  1  one-cycle pulse; `cyc_count` is valid for `prog_sel`
- cyc_count  out  CW  cycle count of the program just completed
- all_done  out  1  sticky; set after all P programs complete
- timeout_err  out  1  sticky; a program exceeded TIMEOUT
- err_prog  out  $clog2(P)  index of the program that timed out

## Operation
States and transitions:
- IDLE: outputs quiescent. `start`=1 → REQ with prog_sel=0, cnt=0, all_done cleared.
- REQ: `req`=1 for exactly REQ_CYC cycles, then → WAIT_LOW. `done` is ignored here.
- WAIT_LOW: waits for the stale `done` from the previous run to drop. done=0 → RUN. cnt increments each cycle.
- RUN: waits for `done`.
  - done=1 → capture cyc_count←cnt, then go to NEXT.
  - Otherwise cnt increments.
- NEXT: pulse `cyc_valid`.
  - If prog_sel==P-1 → FINISH.
  - Otherwise prog_sel+1, cnt=0 → REQ.
- FINISH: set all_done for one cycle → IDLE. all_done stays set until the next `start`.
- ERROR: `req`=0, timeout_err=1, err_prog=prog_sel. `start`=1 clears timeout_err and all_done and goes to REQ with prog_sel=0.

Counter and timeout:
- In WAIT_LOW or RUN, the transition to ERROR happens on the cycle cnt==TIMEOUT, instead of incrementing.
- cnt never wraps.

Boundary conditions:
- `start` while busy is ignored.
- `start` held high restarts a new sequence from IDLE on the cycle after FINISH.
- `done` already low at WAIT_LOW entry: WAIT_LOW lasts one cycle.
- `done` high and low on alternating cycles in RUN: the first sampled 1 completes the program.
- reset asserted mid-sequence: all state returns to IDLE immediately (asynchronous); outputs take their reset values.

## Timing
- Reset values: req=0, prog_sel=0, busy=0, cyc_valid=0, cyc_count=0, all_done=0, timeout_err=0, err_prog=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `start` sampled at edge t → `req`=1 from t+1 through t+REQ_CYC.
- `prog_sel` is stable from REQ entry until the NEXT increment. It never changes while `req` is high.
- `done` first seen high in RUN at edge t → `cyc_valid`=1 during cycle t+1, with `cyc_count` stable from t+1 until the next capture.
- cyc_count = number of WAIT_LOW plus RUN cycles before the completing edge.
- Back-to-back programs: the next `req` rises one cycle after `cyc_valid`.

## Structure
- Shared package `prog_run_pkg`:
  - state enum (IDLE, REQ, WAIT_LOW, RUN, NEXT, FINISH, ERROR)
  - default P, CW, TIMEOUT and REQ_CYC constants
- One sub-module, `wdog_cnt`: CW-bit counter with clear, enable and a `hit` output at TIMEOUT. It is reused for the REQ pulse width with limit REQ_CYC-1.
- FSM and output registers live in `prog_run_seq`.

## Test plan
- Reset mid-RUN:
  - Stimulus: assert reset for 3 cycles with prog_sel=1.
  - Response: all outputs 0, state IDLE; no `req` until the next `start`.
- Nominal sequence:
  - Stimulus: start; a core model holds done low, then raises it after 40, 55 and 70 cycles.
  - Response: three `cyc_valid` pulses with prog_sel 0, 1, 2 and cyc_count 40, 55, 70; all_done=1.
- Stale done:
  - Stimulus: done held high through REQ and for 2 cycles after.
  - Response: WAIT_LOW lasts 3 cycles; the program does not complete early, and that count is included.
- Timeout:
  - Stimulus: TIMEOUT=100; done never rises on program 1.
  - Response: cycle 100 → timeout_err=1, err_prog=1, req=0, busy=0. A following start clears the error and reruns from program 0.
- Ignored start:
  - Stimulus: start pulsed during RUN of program 0.
  - Response: sequence unaffected; exactly P `cyc_valid` pulses.
- REQ_CYC=1 and P=1:
  - Response: single-cycle `req`; FINISH reached directly after the first NEXT.

Source files
------------

// File: rtl/prog_run_pkg.sv
// Shared definitions for the program-run sequencer.
// - state_e : sequencer FSM states
// - Def*    : default parameter values for prog_run_seq
// - sel_w   : width of a program index. It is never zero, so P=1 still yields a 1-bit field.
package prog_run_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitLow,
    StRun,
    StNext,
    StFinish,
    StError
  } state_e;

  localparam int unsigned DefP       = 3;
  localparam int unsigned DefCw      = 16;
  localparam int unsigned DefTimeout = 4095;
  localparam int unsigned DefReqCyc  = 2;

  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prog_run_seq_if.sv
// Request/done handshake between the sequencer and the core.
// - req      : request pulse to the core
// - prog_sel : index of the program being run
// - done     : level from the core, high once its program has finished
// Modports: master (sequencer side), slave (core side).
interface prog_run_seq_if #(
  parameter int unsigned P = prog_run_pkg::DefP
);
  localparam int unsigned SW = prog_run_pkg::sel_w(P);

  logic          req;
  logic [SW-1:0] prog_sel;
  logic          done;

  modport master (output req, output prog_sel, input done);
  modport slave  (input req, input prog_sel, output done);
endinterface

// File: rtl/wdog_cnt.sv
// Saturating up-counter with synchronous clear and an equality flag.
// - clk, reset : clock, asynchronous active-low reset
// - clr        : synchronous clear (wins over en)
// - en         : count enable; the count holds once it reaches LIMIT
// - cnt        : current count
// - hit        : cnt == LIMIT
module wdog_cnt #(
  parameter int unsigned CW    = 16,
  parameter int unsigned LIMIT = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          hit
);

  localparam logic [CW-1:0] LimitW = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  assign hit = (cnt_q == LimitW);
  assign cnt = cnt_q;

  // The count holds at LIMIT, so it never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !hit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_run_seq.sv
// Host-side initiator that runs the core through P resident programs in order.
// For each program it pulses req, waits for done and reports the cycle count.
// A watchdog aborts a program that does not finish within TIMEOUT cycles.
// TIMEOUT must be below 2^CW.
// - clk, reset  : clock, asynchronous active-low reset
// - start       : begin a full sequence (honoured in IDLE and ERROR only)
// - core        : req/prog_sel/done handshake to the core
// - busy        : low in IDLE, FINISH and ERROR
// - cyc_valid   : one-cycle pulse; cyc_count belongs to the current prog_sel
// - cyc_count   : cycle count of the program just completed
// - all_done    : sticky until the next start; set when all P programs complete
// - timeout_err : sticky until the next start; a program timed out
// - err_prog    : index of the program that timed out
module prog_run_seq
  import prog_run_pkg::*;
#(
  parameter int unsigned P       = DefP,
  parameter int unsigned CW      = DefCw,
  parameter int unsigned TIMEOUT = DefTimeout,
  parameter int unsigned REQ_CYC = DefReqCyc,
  localparam int unsigned SW     = sel_w(P)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  prog_run_seq_if.master  core,
  output logic            busy,
  output logic            cyc_valid,
  output logic [CW-1:0]   cyc_count,
  output logic            all_done,
  output logic            timeout_err,
  output logic [SW-1:0]   err_prog
);

  localparam logic [SW-1:0] LastSel = SW'(P - 1);

  state_e        state_q;
  logic          req_q;
  logic [SW-1:0] prog_sel_q;
  logic          busy_q;
  logic          cyc_valid_q;
  logic [CW-1:0] cyc_count_q;
  logic          all_done_q;
  logic          timeout_err_q;
  logic [SW-1:0] err_prog_q;

  logic          wd_clr, wd_en, wd_hit;
  logic [CW-1:0] wd_cnt;
  logic          rq_clr, rq_en, rq_hit;
  logic [CW-1:0] rq_cnt;

  // The watchdog runs only while waiting on the core, so it restarts at 0 on every WAIT_LOW entry.
  always_comb begin
    wd_clr = !((state_q == StWaitLow) || (state_q == StRun));
    wd_en  = !wd_clr;
    rq_clr = (state_q != StReq);
    rq_en  = !rq_clr;
  end

  wdog_cnt #(
    .CW    (CW),
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr   (wd_clr),
    .en    (wd_en),
    .cnt   (wd_cnt),
    .hit   (wd_hit)
  );

  // The same counter times the req pulse; a limit of REQ_CYC-1 gives REQ_CYC cycles in REQ.
  wdog_cnt #(
    .CW    (CW),
    .LIMIT (REQ_CYC - 1)
  ) u_req_w (
    .clk   (clk),
    .reset (reset),
    .clr   (rq_clr),
    .en    (rq_en),
    .cnt   (rq_cnt),
    .hit   (rq_hit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      req_q         <= 1'b0;
      prog_sel_q    <= '0;
      busy_q        <= 1'b0;
      cyc_valid_q   <= 1'b0;
      cyc_count_q   <= '0;
      all_done_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      err_prog_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StError: begin
          if (start) begin
            state_q       <= StReq;
            req_q         <= 1'b1;
            prog_sel_q    <= '0;
            busy_q        <= 1'b1;
            all_done_q    <= 1'b0;
            timeout_err_q <= 1'b0;
          end
        end
        StReq: begin
          if (rq_hit) begin
            state_q <= StWaitLow;
            req_q   <= 1'b0;
          end
        end
        StWaitLow: begin
          if (wd_hit) begin
            state_q       <= StError;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            err_prog_q    <= prog_sel_q;
          end else if (!core.done) begin
            state_q <= StRun;
          end
        end
        StRun: begin
          // A completion seen on the limit cycle still counts as a completion.
          if (core.done) begin
            state_q     <= StNext;
            cyc_count_q <= wd_cnt;
            cyc_valid_q <= 1'b1;
          end else if (wd_hit) begin
            state_q       <= StError;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b1;
            err_prog_q    <= prog_sel_q;
          end
        end
        StNext: begin
          cyc_valid_q <= 1'b0;
          if (prog_sel_q == LastSel) begin
            state_q    <= StFinish;
            busy_q     <= 1'b0;
            all_done_q <= 1'b1;
          end else begin
            state_q    <= StReq;
            req_q      <= 1'b1;
            prog_sel_q <= prog_sel_q + 1'b1;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign core.req      = req_q;
  assign core.prog_sel = prog_sel_q;
  assign busy          = busy_q;
  assign cyc_valid     = cyc_valid_q;
  assign cyc_count     = cyc_count_q;
  assign all_done      = all_done_q;
  assign timeout_err   = timeout_err_q;
  assign err_prog      = err_prog_q;

endmodule

// File: tb/tb_prog_run_seq.sv
module tb_prog_run_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // DUT 0: three programs, short watchdog, two-cycle req.
  logic        start0 = 1'b0;
  logic        busy0, cyc_valid0, all_done0, timeout_err0;
  logic [15:0] cyc_count0;
  logic [1:0]  err_prog0;
  prog_run_seq_if #(.P(3)) u_if0 ();

  prog_run_seq #(.P(3), .CW(16), .TIMEOUT(100), .REQ_CYC(2)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .start       (start0),
    .core        (u_if0.master),
    .busy        (busy0),
    .cyc_valid   (cyc_valid0),
    .cyc_count   (cyc_count0),
    .all_done    (all_done0),
    .timeout_err (timeout_err0),
    .err_prog    (err_prog0)
  );

  // DUT 1: single program, single-cycle req.
  logic        start1 = 1'b0;
  logic        busy1, cyc_valid1, all_done1, timeout_err1;
  logic [7:0]  cyc_count1;
  logic [0:0]  err_prog1;
  prog_run_seq_if #(.P(1)) u_if1 ();

  prog_run_seq #(.P(1), .CW(8), .TIMEOUT(50), .REQ_CYC(1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .start       (start1),
    .core        (u_if1.master),
    .busy        (busy1),
    .cyc_valid   (cyc_valid1),
    .cyc_count   (cyc_count1),
    .all_done    (all_done1),
    .timeout_err (timeout_err1),
    .err_prog    (err_prog1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int lat;      // cycles from WAIT_LOW entry until done is presented
    bit stale;    // done left high from previous run, dropped 2 cycles after req falls
    bit poke;     // pulse start during RUN (must be ignored)
    int sel;
    int exp_cnt;
    bit last;
  } rec_t;

  rec_t tbl[6];

  // Core model for one program on DUT 0 plus the checks around its completion.
  task automatic run_prog(input rec_t r);
    int n;
    int width;
    n = 0;
    while (u_if0.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_rise", u_if0.req, 1);
    if (u_if0.req !== 1'b1) return;
    chk("sel_during_req", u_if0.prog_sel, r.sel);
    if (!r.stale) u_if0.done = 1'b0;
    width = 1;
    n = 0;
    @(negedge clk);
    while (u_if0.req === 1'b1 && n < 20) begin
      width++;
      n++;
      @(negedge clk);
    end
    chk("req_width", width, 2);
    for (int k = 0; k < r.lat; k++) begin
      if (r.stale && k == 2) u_if0.done = 1'b0;
      if (r.poke && k == 5) start0 = 1'b1;
      if (r.poke && k == 6) start0 = 1'b0;
      if (k == 2) chk("no_early_done", cyc_valid0, 0);
      if (k == r.lat / 2) chk("busy_in_run", busy0, 1);
      @(negedge clk);
    end
    u_if0.done = 1'b1;
    @(negedge clk);
    chk("cyc_valid", cyc_valid0, 1);
    chk("cyc_count", cyc_count0, r.exp_cnt);
    chk("cyc_sel", u_if0.prog_sel, r.sel);
    @(negedge clk);
    chk("cyc_valid_pulse", cyc_valid0, 0);
    if (r.last) begin
      chk("all_done", all_done0, 1);
      chk("busy_finish", busy0, 0);
    end else begin
      chk("next_req", u_if0.req, 1);
    end
  endtask

  initial begin
    int n;
    tbl[0] = '{lat: 40, stale: 0, poke: 0, sel: 0, exp_cnt: 40, last: 0};
    tbl[1] = '{lat: 55, stale: 0, poke: 0, sel: 1, exp_cnt: 55, last: 0};
    tbl[2] = '{lat: 70, stale: 0, poke: 0, sel: 2, exp_cnt: 70, last: 1};
    tbl[3] = '{lat: 12, stale: 1, poke: 1, sel: 0, exp_cnt: 12, last: 0};
    tbl[4] = '{lat: 8,  stale: 1, poke: 0, sel: 1, exp_cnt: 8,  last: 0};
    tbl[5] = '{lat: 5,  stale: 1, poke: 0, sel: 2, exp_cnt: 5,  last: 1};

    u_if0.done = 1'b0;
    u_if1.done = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req", u_if0.req, 0);
    chk("rst_sel", u_if0.prog_sel, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_cyc_valid", cyc_valid0, 0);
    chk("rst_cyc_count", cyc_count0, 0);
    chk("rst_all_done", all_done0, 0);
    chk("rst_timeout_err", timeout_err0, 0);
    chk("rst_err_prog", err_prog0, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Nominal sequence, then a sequence with stale done and an ignored start.
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_prog(tbl[i]);
      if (i == 2) begin
        // start held across FINISH restarts from IDLE.
        start0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start0 = 1'b0;
        chk("all_done_cleared", all_done0, 0);
      end
    end

    // Timeout on program 1.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    run_prog('{lat: 20, stale: 0, poke: 0, sel: 0, exp_cnt: 20, last: 0});
    u_if0.done = 1'b0;
    n = 0;
    while (u_if0.req === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (100) @(negedge clk);
    chk("to_not_yet", timeout_err0, 0);
    chk("to_busy_before", busy0, 1);
    @(negedge clk);
    chk("to_err", timeout_err0, 1);
    chk("to_err_prog", err_prog0, 1);
    chk("to_req", u_if0.req, 0);
    chk("to_busy", busy0, 0);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("to_clear", timeout_err0, 0);
    chk("to_rerun_req", u_if0.req, 1);
    chk("to_rerun_sel", u_if0.prog_sel, 0);

    // Reset in the middle of program 1.
    run_prog('{lat: 15, stale: 0, poke: 0, sel: 0, exp_cnt: 15, last: 0});
    u_if0.done = 1'b0;
    n = 0;
    while (u_if0.req === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    chk("mid_sel", u_if0.prog_sel, 1);
    reset = 1'b0;
    #1;
    chk("arst_busy", busy0, 0);
    repeat (3) @(negedge clk);
    chk("mr_req", u_if0.req, 0);
    chk("mr_sel", u_if0.prog_sel, 0);
    chk("mr_busy", busy0, 0);
    chk("mr_cyc_count", cyc_count0, 0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("mr_no_req", u_if0.req, 0);
    chk("mr_idle", busy0, 0);

    // Single program with single-cycle req.
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("p1_req", u_if1.req, 1);
    chk("p1_sel", u_if1.prog_sel, 0);
    @(negedge clk);
    chk("p1_req_1cyc", u_if1.req, 0);
    repeat (5) @(negedge clk);
    u_if1.done = 1'b1;
    @(negedge clk);
    chk("p1_cyc_valid", cyc_valid1, 1);
    chk("p1_cyc_count", cyc_count1, 5);
    @(negedge clk);
    chk("p1_all_done", all_done1, 1);
    chk("p1_busy", busy1, 0);
    chk("p1_no_req", u_if1.req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
